// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, total helpers and sync bundle type
package vga_pkg;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  function automatic int h_total(input int disp, input int front, input int sync, input int back);
    return disp + front + sync + back;
  endfunction

  function automatic int v_total(input int disp, input int front, input int sync, input int back);
    return disp + front + sync + back;
  endfunction

  // Internal sync levels are active-high; polarity is applied only at the top outputs.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_bundle_t;

  localparam sync_bundle_t SYNC_IDLE = '0;

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - enable-gated shift register of sync bundles, reset to idle
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  sync_bundle_t d_i,
  output sync_bundle_t q_o
);

  if (DEPTH == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_shift
    sync_bundle_t stage_q [DEPTH];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= SYNC_IDLE;
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing: pixel enable, position, syncs, strobes, frame count
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY  = DEF_H_DISPLAY,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_DISPLAY  = DEF_V_DISPLAY,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int CLK_DIV    = 1,
  parameter int PIPE_DELAY = 0,
  parameter int COORD_W    = 10,
  parameter int FRAME_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pix_en,
  output logic [COORD_W-1:0] hpos,
  output logic [COORD_W-1:0] vpos,
  output logic               display_on,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [31:0] HS_START = 32'(H_DISPLAY + H_FRONT);
  localparam logic [31:0] HS_END   = 32'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_DISPLAY + V_FRONT);
  localparam logic [31:0] VS_END   = 32'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [31:0] H_VIS    = 32'(H_DISPLAY);
  localparam logic [31:0] V_VIS    = 32'(V_DISPLAY);
  localparam logic HS_POL = HSYNC_POL[0];
  localparam logic VS_POL = VSYNC_POL[0];

  if (CLK_DIV < 1 || PIPE_DELAY < 0 || PIPE_DELAY > 7 ||
      H_TOTAL - 1 >= (1 << COORD_W) || V_TOTAL - 1 >= (1 << COORD_W)) begin : g_param_check
    $error("vga_timing_gen: illegal CLK_DIV, PIPE_DELAY or COORD_W");
  end

  logic [DIV_W-1:0]   div_q, div_d;
  logic               pix_q, pix_d;
  logic [COORD_W-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic [COORD_W-1:0] next_h, next_v;
  logic               line_q, line_d, frame_q, frame_d;
  logic [FRAME_W-1:0] fcnt_q, fcnt_d;
  sync_bundle_t       sync_q, sync_d, raw, dly;
  logic [31:0]        nh, nv;

  always_comb begin
    div_d = div_q + DIV_W'(1);
    pix_d = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      pix_d = 1'b1;
    end

    next_h = hpos_q + COORD_W'(1);
    next_v = vpos_q;
    if (hpos_q == H_LAST) begin
      next_h = '0;
      next_v = (vpos_q == V_LAST) ? '0 : vpos_q + COORD_W'(1);
    end

    // Syncs are derived from the position about to be loaded so they line up with hpos/vpos.
    nh     = 32'(next_h);
    nv     = 32'(next_v);
    raw.de = (nh < H_VIS) && (nv < V_VIS);
    raw.hs = (nh >= HS_START) && (nh < HS_END);
    raw.vs = (nv >= VS_START) && (nv < VS_END);

    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    sync_d  = sync_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    fcnt_d  = fcnt_q;
    if (pix_q) begin
      hpos_d  = next_h;
      vpos_d  = next_v;
      sync_d  = raw;
      line_d  = (next_h == '0);
      frame_d = (next_h == '0) && (next_v == '0);
      if (frame_d) fcnt_d = fcnt_q + FRAME_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      pix_q   <= 1'b0;
      hpos_q  <= '0;
      vpos_q  <= '0;
      sync_q  <= SYNC_IDLE;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      div_q   <= div_d;
      pix_q   <= pix_d;
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      sync_q  <= sync_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      fcnt_q  <= fcnt_d;
    end
  end

  vga_delay_line #(.DEPTH(PIPE_DELAY)) u_delay (
    .clk   (clk),
    .reset (reset),
    .en_i  (pix_q),
    .d_i   (sync_q),
    .q_o   (dly)
  );

  assign pix_en      = pix_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign display_on  = dly.de;
  assign hsync       = dly.hs ^ ~HS_POL;
  assign vsync       = dly.vs ^ ~VS_POL;
  assign line_start  = line_q;
  assign frame_start = frame_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - two tiny-mode instances checked against a closed-form timing model
module tb_vga_timing_gen;

  localparam int HT = 7;
  localparam int VT = 5;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic       pix;
    logic       ls;
    logic       fs;
    logic       de;
    logic       hs;
    logic       vs;
    logic [3:0] h;
    logic [3:0] v;
    logic [1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       a_pix, a_de, a_hs, a_vs, a_ls, a_fs;
  logic [3:0] a_h, a_v;
  logic [1:0] a_fc;
  logic       b_pix, b_de, b_hs, b_vs, b_ls, b_fs;
  logic [3:0] b_h, b_v;
  logic [1:0] b_fc;

  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_DISPLAY(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(0), .VSYNC_POL(0), .CLK_DIV(1), .PIPE_DELAY(0),
    .COORD_W(4), .FRAME_W(2)
  ) dut_a (
    .clk(clk), .reset(reset), .pix_en(a_pix), .hpos(a_h), .vpos(a_v),
    .display_on(a_de), .hsync(a_hs), .vsync(a_vs),
    .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
  );

  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_DISPLAY(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .CLK_DIV(4), .PIPE_DELAY(3),
    .COORD_W(4), .FRAME_W(2)
  ) dut_b (
    .clk(clk), .reset(reset), .pix_en(b_pix), .hpos(b_h), .vpos(b_v),
    .display_on(b_de), .hsync(b_hs), .vsync(b_vs),
    .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
  );

  int n_pass = 0;
  int n_total = 0;
  exp_t qa[$];
  exp_t qb[$];

  // n = clock edges since the edge that sampled reset high.
  function automatic exp_t model(input int n, input int d, input int p, input int hpol, input int vpol);
    exp_t e;
    int k, pos, j, q, hh, vv;
    logic tick, de, hs, vs;
    k     = (n >= 1) ? (n - 1) / d : 0;
    pos   = k % FT;
    e.h   = 4'(pos % HT);
    e.v   = 4'(pos / HT);
    e.pix = (n >= 1) && (n % d == 0);
    tick  = (k >= 1) && ((n - 1) % d == 0);
    e.ls  = tick && (pos % HT == 0);
    e.fs  = tick && (pos == 0);
    e.fc  = 2'((k / FT) % 4);
    j = k - p;
    de = 1'b0; hs = 1'b0; vs = 1'b0;
    if (j >= 1) begin
      q  = j % FT;
      hh = q % HT;
      vv = q / HT;
      de = (hh < 4) && (vv < 2);
      hs = (hh == 5);
      vs = (vv == 3);
    end
    e.de = de;
    e.hs = (hpol != 0) ? hs : ~hs;
    e.vs = (vpol != 0) ? vs : ~vs;
    return e;
  endfunction

  task automatic cmp(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, exp);
  endtask

  task automatic check(input string who, input int n, input exp_t o, input exp_t e);
    cmp({who, ".pix_en"},      n, 32'(o.pix), 32'(e.pix));
    cmp({who, ".hpos"},        n, 32'(o.h),   32'(e.h));
    cmp({who, ".vpos"},        n, 32'(o.v),   32'(e.v));
    cmp({who, ".display_on"},  n, 32'(o.de),  32'(e.de));
    cmp({who, ".hsync"},       n, 32'(o.hs),  32'(e.hs));
    cmp({who, ".vsync"},       n, 32'(o.vs),  32'(e.vs));
    cmp({who, ".line_start"},  n, 32'(o.ls),  32'(e.ls));
    cmp({who, ".frame_start"}, n, 32'(o.fs),  32'(e.fs));
    cmp({who, ".frame_cnt"},   n, 32'(o.fc),  32'(e.fc));
  endtask

  task automatic run_phase(input int cycles);
    exp_t oa, ob, ea, eb;
    for (int n = 0; n <= cycles; n++) begin
      @(posedge clk);
      qa.push_back(model(n, 1, 0, 0, 0));
      qb.push_back(model(n, 4, 3, 1, 1));
      @(negedge clk);
      if (n == 0) reset = 1'b0;
      oa = '{pix:a_pix, ls:a_ls, fs:a_fs, de:a_de, hs:a_hs, vs:a_vs, h:a_h, v:a_v, fc:a_fc};
      ob = '{pix:b_pix, ls:b_ls, fs:b_fs, de:b_de, hs:b_hs, vs:b_vs, h:b_h, v:b_v, fc:b_fc};
      ea = qa.pop_front();
      eb = qb.pop_front();
      check("A", n, oa, ea);
      check("B", n, ob, eb);
    end
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clk);
    run_phase(300);
    // One-cycle reset asserted mid-frame on both instances.
    reset = 1'b1;
    run_phase(800);
    cmp("queue_a_drained", 0, 32'(qa.size()), 32'd0);
    cmp("queue_b_drained", 0, 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
